// File: rtl/sha256_chain_engine.sv
// sha256_chain_engine: chained SHA-256/224 block compressor, 1/2/4 rounds per clock, 16-word sliding schedule
module sha256_chain_engine #(
    parameter int ROUNDS_PER_CLK = 1,
    parameter int SUPPORT_224    = 1
) (
    input  logic         clk_100mhz,
    input  logic         rst_i,
    input  logic         blk_valid_i,
    output logic         blk_ready_o,
    input  logic [511:0] blk_data_i,
    input  logic         blk_first_i,
    input  logic         blk_last_i,
    input  logic         mode_224_i,
    input  logic         abort_i,
    output logic         hash_valid_o,
    input  logic         hash_ready_i,
    output logic [255:0] hash_o,
    output logic         busy_o,
    output logic [31:0]  blk_count_o
);
    if (ROUNDS_PER_CLK != 1 && ROUNDS_PER_CLK != 2 && ROUNDS_PER_CLK != 4) begin : g_bad_rpc
        $error("ROUNDS_PER_CLK must be 1, 2 or 4");
    end

    // element 0 is H0 / a
    localparam logic [7:0][31:0] IV256 = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
    localparam logic [7:0][31:0] IV224 = {
        32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
        32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8};
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    typedef enum logic [1:0] {IDLE, ROUND, ADD, DONE} state_t;

    state_t            state, state_nxt;
    logic [7:0][31:0]  h, v, rv, iv;
    logic [15:0][31:0] win, rw;
    logic [5:0]        t_cnt;
    logic [31:0]       t1, t2, nw;
    logic              last_q, mode_q, mode_in, accept, t_end;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    assign mode_in = (SUPPORT_224 != 0) && mode_224_i;
    assign iv      = mode_in ? IV224 : IV256;
    assign accept  = blk_valid_i && blk_ready_o;
    assign t_end   = t_cnt == 6'(64 - ROUNDS_PER_CLK);
    assign busy_o  = state != IDLE;
    assign hash_o  = {h[0], h[1], h[2], h[3], h[4], h[5], h[6], mode_q ? 32'h0 : h[7]};

    // ROUNDS_PER_CLK rounds chained combinationally, window sliding one word per round
    always_comb begin
        rv = v;
        rw = win;
        t1 = '0;
        t2 = '0;
        nw = '0;
        for (int r = 0; r < ROUNDS_PER_CLK; r++) begin
            t1 = rv[7] + (ror(rv[4], 6) ^ ror(rv[4], 11) ^ ror(rv[4], 25))
               + ((rv[4] & rv[5]) ^ (~rv[4] & rv[6])) + K[t_cnt + 6'(r)] + rw[0];
            t2 = (ror(rv[0], 2) ^ ror(rv[0], 13) ^ ror(rv[0], 22))
               + ((rv[0] & rv[1]) ^ (rv[0] & rv[2]) ^ (rv[1] & rv[2]));
            nw = rw[0] + (ror(rw[1], 7) ^ ror(rw[1], 18) ^ (rw[1] >> 3)) + rw[9]
               + (ror(rw[14], 17) ^ ror(rw[14], 19) ^ (rw[14] >> 10));
            rv = {rv[6:4], rv[3] + t1, rv[2:0], t1 + t2};
            rw = {nw, rw[15:1]};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? ROUND : IDLE;
            ROUND:   state_nxt = t_end ? ADD : ROUND;
            ADD:     state_nxt = last_q ? DONE : IDLE;
            DONE:    state_nxt = hash_ready_i ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst_i || abort_i) begin
            state        <= IDLE;
            blk_ready_o  <= 1'b1;
            hash_valid_o <= 1'b0;
        end else begin
            state        <= state_nxt;
            blk_ready_o  <= state_nxt == IDLE;
            hash_valid_o <= state_nxt == DONE;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst_i || abort_i) begin
            h           <= IV256;
            mode_q      <= 1'b0;
            blk_count_o <= '0;
        end else if (state == IDLE && accept) begin
            for (int i = 0; i < 16; i++) win[i] <= blk_data_i[511 - 32*i -: 32];
            t_cnt  <= '0;
            last_q <= blk_last_i;
            if (blk_first_i) begin
                h           <= iv;
                v           <= iv;
                mode_q      <= mode_in;
                blk_count_o <= 32'd1;
            end else begin
                v           <= h;
                blk_count_o <= blk_count_o + 32'd1;
            end
        end else if (state == ROUND) begin
            v     <= rv;
            win   <= rw;
            t_cnt <= t_cnt + 6'(ROUNDS_PER_CLK);
        end else if (state == ADD) begin
            for (int i = 0; i < 8; i++) h[i] <= h[i] + v[i];
        end
    end
endmodule

// File: tb/tb_sha256_chain_engine.sv
// tb_sha256_chain_engine: R=1 (with SHA-224) and R=4 (SHA-256 only) engines checked against a plain SHA-256 model
module tb_sha256_chain_engine;
    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [511:0] TWO_B1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_B2    = {480'h0, 32'h000001c0};
    localparam logic [255:0] ABC256   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] TWO256   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [255:0] EMPTY256 = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] ABC224   = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
    localparam logic [255:0] IV256    = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] IV224    = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic         clk = 1'b0;
    logic         rst;
    logic         blk_valid [2], blk_ready [2], blk_first [2], blk_last [2], mode_224 [2], abort [2];
    logic         hash_valid [2], hash_ready [2], busy [2];
    logic [511:0] blk_data [2];
    logic [255:0] hash [2];
    logic [31:0]  blk_count [2];

    logic [255:0] m_h [2];
    logic         m_mode [2], m_pend [2];
    logic [31:0]  m_count [2];
    int           cyc = 0, e0 [2], n_chk = 0, n_err = 0;
    bit           chk_on = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sha256_chain_engine #(.ROUNDS_PER_CLK(1), .SUPPORT_224(1)) u_r1 (
        .clk_100mhz(clk), .rst_i(rst), .blk_valid_i(blk_valid[0]), .blk_ready_o(blk_ready[0]),
        .blk_data_i(blk_data[0]), .blk_first_i(blk_first[0]), .blk_last_i(blk_last[0]),
        .mode_224_i(mode_224[0]), .abort_i(abort[0]), .hash_valid_o(hash_valid[0]),
        .hash_ready_i(hash_ready[0]), .hash_o(hash[0]), .busy_o(busy[0]), .blk_count_o(blk_count[0]));

    sha256_chain_engine #(.ROUNDS_PER_CLK(4), .SUPPORT_224(0)) u_r4 (
        .clk_100mhz(clk), .rst_i(rst), .blk_valid_i(blk_valid[1]), .blk_ready_o(blk_ready[1]),
        .blk_data_i(blk_data[1]), .blk_first_i(blk_first[1]), .blk_last_i(blk_last[1]),
        .mode_224_i(mode_224[1]), .abort_i(abort[1]), .hash_valid_o(hash_valid[1]),
        .hash_ready_i(hash_ready[1]), .hash_o(hash[1]), .busy_o(busy[1]), .blk_count_o(blk_count[1]));

    function automatic int rpc(input int u);
        return u == 0 ? 1 : 4;
    endfunction

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // textbook compression with a full 64-word schedule
    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  s [8];
        logic [31:0]  n [8];
        logic [31:0]  t1, t2;
        logic [255:0] res;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        for (int i = 0; i < 8; i++) s[i] = hin[255 - 32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = s[7] + (rr(s[4], 6) ^ rr(s[4], 11) ^ rr(s[4], 25)) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[i] + w[i];
            t2 = (rr(s[0], 2) ^ rr(s[0], 13) ^ rr(s[0], 22)) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
            n = '{t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
            s = n;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + s[i];
        return res;
    endfunction

    function automatic logic [255:0] m_digest(input int u);
        return m_mode[u] ? {m_h[u][255:32], 32'h0} : m_h[u];
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset(input int u);
        m_h[u] = IV256; m_mode[u] = 0; m_count[u] = 0; m_pend[u] = 0;
    endtask

    task automatic model_accept(input int u, input logic [511:0] d, input logic first, last, m224);
        if (first) begin
            m_mode[u]  = (u == 0) && m224;
            m_h[u]     = m_mode[u] ? IV224 : IV256;
            m_count[u] = 1;
        end else m_count[u] = m_count[u] + 1;
        m_h[u] = compress(m_h[u], d);
        if (last) m_pend[u] = 1;
    endtask

    task automatic send_block(input int u, input logic [511:0] d, input logic first, last, m224);
        int n = 0;
        @(negedge clk);
        blk_valid[u] = 1; blk_data[u] = d; blk_first[u] = first; blk_last[u] = last; mode_224[u] = m224;
        while (!blk_ready[u] && n < 300) begin @(negedge clk); n++; end
        chk("accept_wait", 256'(blk_ready[u]), 256'(1));
        if (!blk_ready[u]) begin blk_valid[u] = 0; return; end
        @(posedge clk); #1;
        e0[u] = cyc;
        model_accept(u, d, first, last, m224);
        blk_valid[u] = 0; blk_first[u] = 0; blk_last[u] = 0; mode_224[u] = 0;
    endtask

    task automatic finish_block(input int u, input logic last, input int hold, input bit bp,
                                input bit use_lit, input logic [255:0] lit);
        int n = 0;
        logic [255:0] snap;
        logic [31:0]  cnt;
        do begin @(negedge clk); n++; end while (!(last ? hash_valid[u] : blk_ready[u]) && n < 300);
        chk("done_wait", 256'(last ? hash_valid[u] : blk_ready[u]), 256'(1));
        chk("latency", 256'(cyc - e0[u]), 256'(64 / rpc(u) + 1));
        if (last) begin
            if (use_lit) begin
                chk("digest_literal", hash[u], lit);
                chk("model_literal", m_digest(u), lit);
            end
            snap = hash[u];
            cnt  = blk_count[u];
            if (bp) begin blk_valid[u] = 1; blk_data[u] = {16{$urandom}}; blk_first[u] = 1; end
            repeat (hold) begin
                @(negedge clk);
                chk("hold_hash", hash[u], snap);
                chk("hold_valid", 256'(hash_valid[u]), 256'(1));
                chk("hold_ready", 256'(blk_ready[u]), 256'(0));
                chk("hold_count", 256'(blk_count[u]), 256'(cnt));
            end
            hash_ready[u] = 1; blk_valid[u] = 0; blk_first[u] = 0;
            @(posedge clk); #1;
            m_pend[u] = 0;
            @(negedge clk);
            hash_ready[u] = 0;
            chk("release_ready", 256'(blk_ready[u]), 256'(1));
            chk("release_valid", 256'(hash_valid[u]), 256'(0));
        end
    endtask

    task automatic check_idle(input string nm, input int u);
        chk({nm, "_ready"}, 256'(blk_ready[u]), 256'(1));
        chk({nm, "_valid"}, 256'(hash_valid[u]), 256'(0));
        chk({nm, "_busy"}, 256'(busy[u]), 256'(0));
        chk({nm, "_count"}, 256'(blk_count[u]), 256'(0));
        chk({nm, "_hash"}, hash[u], IV256);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        model_reset(0); model_reset(1);
        @(negedge clk); rst = 0;
        for (int u = 0; u < 2; u++) check_idle("reset", u);
    endtask

    task automatic do_abort(input int u);
        @(negedge clk); abort[u] = 1;
        @(posedge clk); #1;
        model_reset(u);
        @(negedge clk); abort[u] = 0;
        check_idle("abort", u);
    endtask

    task automatic rand_blocks(input int u, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            logic [511:0] d;
            logic f, l, m;
            for (int j = 0; j < 16; j++) d[32*j +: 32] = $urandom;
            f = $urandom_range(0, 2) == 0;
            l = $urandom_range(0, 2) == 0;
            m = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_block(u, d, f, l, m);
            finish_block(u, l, $urandom_range(0, 3), 0, 0, '0);
        end
    endtask

    initial begin
        rst = 1;
        for (int u = 0; u < 2; u++) begin
            blk_valid[u] = 0; blk_first[u] = 0; blk_last[u] = 0; mode_224[u] = 0;
            abort[u] = 0; hash_ready[u] = 0; blk_data[u] = '0;
        end
        fork
            forever begin
                @(negedge clk);
                if (chk_on) for (int u = 0; u < 2; u++) begin
                    chk("busy_vs_ready", 256'(busy[u]), 256'(!blk_ready[u]));
                    chk("blk_count", 256'(blk_count[u]), 256'(m_count[u]));
                    if (hash_valid[u]) begin
                        chk("valid_without_last", 256'(m_pend[u]), 256'(1));
                        chk("digest", hash[u], m_digest(u));
                    end
                end
            end
            begin
                #1_000_000;
                $display("FAIL watchdog expired at cycle %0d", cyc);
                $fatal(1, "watchdog");
            end
        join_none

        do_reset();
        chk_on = 1;

        send_block(0, ABC_BLK, 1, 1, 0);
        finish_block(0, 1, 0, 0, 1, ABC256);

        send_block(0, TWO_B1, 1, 0, 0);
        finish_block(0, 0, 0, 0, 0, '0);
        repeat (5) @(negedge clk);
        send_block(0, TWO_B2, 0, 1, 0);
        chk("two_block_count", 256'(blk_count[0]), 256'(2));
        finish_block(0, 1, 0, 0, 1, TWO256);

        send_block(0, ABC_BLK, 1, 1, 1);
        finish_block(0, 1, 0, 0, 1, ABC224);
        send_block(0, ABC_BLK, 1, 1, 0);
        finish_block(0, 1, 0, 0, 1, ABC256);

        send_block(0, ABC_BLK, 1, 1, 0);
        finish_block(0, 1, 10, 1, 1, ABC256);

        // abort while the second block is at round 30
        send_block(0, TWO_B1, 1, 0, 0);
        finish_block(0, 0, 0, 0, 0, '0);
        send_block(0, TWO_B2, 0, 1, 0);
        repeat (30) @(posedge clk);
        do_abort(0);
        send_block(0, ABC_BLK, 0, 1, 0);
        chk("nonfirst_count", 256'(blk_count[0]), 256'(1));
        finish_block(0, 1, 0, 0, 1, ABC256);

        send_block(0, TWO_B1, 1, 0, 0);
        repeat (10) @(posedge clk);
        do_reset();
        send_block(0, ABC_BLK, 1, 1, 0);
        finish_block(0, 1, 2, 0, 1, ABC256);

        rand_blocks(0, 30);

        send_block(1, EMPTY_BLK, 1, 1, 0);
        finish_block(1, 1, 0, 0, 1, EMPTY256);
        send_block(1, ABC_BLK, 1, 1, 1);
        finish_block(1, 1, 0, 0, 1, ABC256);
        send_block(1, TWO_B1, 1, 0, 1);
        finish_block(1, 0, 0, 0, 0, '0);
        send_block(1, TWO_B2, 0, 1, 0);
        finish_block(1, 1, 3, 1, 1, TWO256);
        rand_blocks(1, 12);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/sha256_chain_engine.md
Name: sha256_chain_engine

Overview:
Parametrised successor to the single-shot SHA-256 engine. It processes a stream of pre-padded 512-bit blocks with valid/ready handshakes and chains the intermediate hash across blocks. It supports SHA-256 and SHA-224 modes and computes 1, 2 or 4 rounds per clock. The message schedule is a 16-word sliding window, with no 64-word W array. It sits between the block FIFO and the hash result register.

Parameters:
ROUNDS_PER_CLK, 1, rounds per cycle; legal values 1, 2, 4; any other value is an elaboration error.
SUPPORT_224, 1, 0 removes the SHA-224 IV mux; mode_224_i is then ignored and treated as 0.

Ports:
clk_100mhz  in  1  system clock
rst_i  in  1  synchronous reset, active-high
blk_valid_i  in  1  input block valid
blk_ready_o  out  1  engine can accept a block
blk_data_i  in  512  padded block; word 0 = [511:480], word 15 = [31:0]
blk_first_i  in  1  block starts a new message; H loads the IV
blk_last_i  in  1  block ends the message; digest is emitted
mode_224_i  in  1  SHA-224 select; sampled only on an accepted first block
abort_i  in  1  synchronous abort of the current message
hash_valid_o  out  1  digest valid
hash_ready_i  in  1  digest consumed
hash_o  out  256  digest {H0..H7}; in 224 mode {H0..H6, 32'h0}
busy_o  out  1  state is not IDLE
blk_count_o  out  32  blocks absorbed in the current message

Behaviour:
- Reset values (rst_i high at a rising edge):
  - state = IDLE, blk_ready_o = 1, hash_valid_o = 0, busy_o = 0, blk_count_o = 0.
  - H = SHA-256 IV, so hash_o = 6a09e667…5be0cd19.
  - mode latch = 0.
- rst_i has priority over abort_i, and abort_i has priority over every handshake.
- The 64 K constants are a combinational ROM, not reset-loaded registers.
- States:
  - IDLE: blk_ready_o = 1. On blk_valid_i & blk_ready_o (edge E0), latch the 16 words into the window and set t = 0.
    - If blk_first_i: H <= IV (224 or 256 per mode_224_i), latch the mode, a..h <= that IV, blk_count_o <= 1.
    - Otherwise: a..h <= H, blk_count_o <= blk_count_o + 1 (wraps at 2^32).
    - Latch blk_last_i, then go to ROUND.
  - ROUND: each edge performs ROUNDS_PER_CLK chained rounds.
    - Round t uses W_t = win[0] and K[t].
    - Window update per round: shift left by one word; new win[15] = win[0] + σ0(win[1]) + win[9] + σ1(win[14]).
    - σ0 = ror7 ^ ror18 ^ shr3; σ1 = ror17 ^ ror19 ^ shr10.
    - Σ0(a) = ror2 ^ ror13 ^ ror22; Σ1(e) = ror6 ^ ror11 ^ ror25.
    - Ch = (e&f) ^ (~e&g); Maj = (a&b) ^ (a&c) ^ (b&c).
    - All additions are modulo 2^32.
    - t += ROUNDS_PER_CLK. When t reaches 64, go to ADD.
  - ADD: one cycle, Hi <= Hi + working variable (mod 2^32).
    - If last: go to DONE and set hash_valid_o <= 1.
    - Otherwise: go to IDLE and set blk_ready_o <= 1.
  - DONE: hash_valid_o = 1 and hash_o is stable.
    - On hash_ready_i: hash_valid_o <= 0, go to IDLE, blk_ready_o <= 1.
- blk_ready_o is registered and low in ROUND, ADD and DONE. blk_valid_i is ignored while blk_ready_o = 0.
- Latency from acceptance edge E0:
  - ADD occupies the cycle after edge 64/R.
  - hash_valid_o (or blk_ready_o for a non-last block) rises at edge 64/R + 1.
  - R=1: 65 cycles; R=2: 33; R=4: 17.
- Throughput: one block per 64/R + 2 cycles at best.
- Non-first block with no prior first since reset/abort: H is already the SHA-256 IV, so the result equals a first block in 256 mode.
- Message boundaries:
  - blk_first_i & blk_last_i together: single-block message.
  - A first block arriving mid-message restarts the chain; the previous partial state is discarded.
- abort_i in any state:
  - Next edge: IDLE, blk_ready_o = 1, hash_valid_o = 0, blk_count_o = 0.
  - H = SHA-256 IV, mode latch = 0; the in-flight block is dropped.
- hash_o always reflects the H register. It is only meaningful while hash_valid_o = 1.

Test Plan:
- "abc" single block (61626380 00…00 00000018), first & last, R=1 → hash_valid_o at edge 65; hash_o = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first on block 1, last on block 2, blk_valid_i idle 5 cycles between blocks) → 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; blk_count_o = 2.
- Empty message (80000000 00…00) with R=4 → hash_valid_o at edge 17; hash_o = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- SHA-224 "abc" (mode_224_i = 1 on first) → 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000. A following 256-mode first block yields the correct SHA-256 digest.
- Backpressure: hash_ready_i held low for 10 cycles with blk_valid_i high → hash_valid_o and hash_o stable, blk_ready_o = 0, no block absorbed. On release, blk_ready_o rises on the following edge.
- abort_i at t = 30 of block 2, then rst_i pulsed mid-ROUND on a later message → each returns to IDLE next edge with blk_count_o = 0 and hash_valid_o = 0. A subsequent "abc" gives the correct digest.
